// File: rtl/mp3_reorder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp3_reorder_pkg
//  Description : Shared constants, short-block scalefactor-band width tables
//                and FSM state encoding for the granule reorder read side.
//  Revision    : 1.0  initial release
// ============================================================================
package mp3_reorder_pkg;

    localparam int GRANULE_SAMPLES    = 576;
    localparam int MIXED_LONG_SAMPLES = 36;
    localparam int SHORT_SFB_COUNT    = 13;

    // In mixed blocks the long part covers exactly short bands 0..2
    // (3 windows x 3 bands x 4 lines = 36), so the short walk resumes at band 3.
    localparam int MIXED_FIRST_SFB    = 3;

    // Short-block band widths, indexed [rate][sfb]; rate 0=44.1k, 1=48k, 2=32k.
    // Every row sums to 192 = 576/3.
    localparam logic [6:0] SHORT_SFB_WIDTH [3][13] = '{
        '{7'd4, 7'd4, 7'd4, 7'd4, 7'd6, 7'd8, 7'd10, 7'd12, 7'd14, 7'd18, 7'd22, 7'd30, 7'd56},
        '{7'd4, 7'd4, 7'd4, 7'd4, 7'd6, 7'd6, 7'd10, 7'd12, 7'd14, 7'd16, 7'd20, 7'd26, 7'd66},
        '{7'd4, 7'd4, 7'd4, 7'd4, 7'd6, 7'd8, 7'd12, 7'd16, 7'd20, 7'd26, 7'd34, 7'd42, 7'd12}
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sfb_width_rom.sv
`default_nettype none
// ============================================================================
//  Module      : sfb_width_rom
//  Description : Combinational lookup of a short-block scalefactor-band width.
//  Ports       : sfreq  in  2  sample-rate code (3 is treated as 44.1k)
//                sfb    in  4  short band index 0..12
//                width  out 7  band width in lines (0 for sfb > 12)
//  Revision    : 1.0  initial release
// ============================================================================
module sfb_width_rom
    import mp3_reorder_pkg::*;
(
    input  logic [1:0] sfreq,
    input  logic [3:0] sfb,
    output logic [6:0] width
);

    logic [1:0] w_rate;

    always_comb begin
        w_rate = (sfreq == 2'd3) ? 2'd0 : sfreq;
        width  = 7'd0;
        // Index 13 is probed after the last band of a granule; answer 0 there.
        if (sfb < 4'(SHORT_SFB_COUNT)) begin
            width = SHORT_SFB_WIDTH[w_rate][sfb];
        end
    end

endmodule
`default_nettype wire

// File: rtl/reorder_reader.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_reader
//  Description : Read-side address generator for the granule sample buffer.
//                Walks output positions 0..SAMPLES-1 in frequency order and
//                emits the buffer address holding each sample: identity for
//                long blocks, (sfb, freq, window) interleave for short blocks,
//                identity-then-interleave for mixed blocks.
//  Ports       : clk, rst_n (async, active low)
//                start, grch_in, window_switching_flag, block_type,
//                mixed_block_flag, sfreq          - granule request/side info
//                rd_ready                         - downstream accept
//                rd_addr, out_idx, grch_out, rd_v - registered beat
//                busy, done                       - status
//  Revision    : 1.0  initial release
// ============================================================================
module reorder_reader
    import mp3_reorder_pkg::*;
#(
    parameter int SAMPLES = 576,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        grch_in,
    input  logic              window_switching_flag,
    input  logic [1:0]        block_type,
    input  logic              mixed_block_flag,
    input  logic [1:0]        sfreq,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] out_idx,
    output logic [1:0]        grch_out,
    output logic              rd_v,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(SAMPLES - 1);
    localparam logic [ADDR_W-1:0] c_mixed_end = ADDR_W'(MIXED_LONG_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] c_mixed_base = ADDR_W'(MIXED_LONG_SAMPLES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [1:0]        r_grch;
    logic [1:0]        r_sfreq;
    logic              r_mixed;     // short+mixed granule
    logic              r_ident;     // current beat uses identity addressing
    logic [3:0]        r_sfb;
    logic [6:0]        r_freq;
    logic [1:0]        r_win;
    logic [6:0]        r_w;         // width of band r_sfb
    logic [ADDR_W-1:0] r_base;      // 3 * start(r_sfb)
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_out_idx;
    logic              r_rd_v;
    logic              r_busy;
    logic              r_done;

    // ------------------------------------------------------------------
    // Width lookup. In IDLE it resolves the first band of the incoming
    // granule; in RUN it pre-fetches the width of the following band so the
    // next address is ready when the current band ends.
    // ------------------------------------------------------------------
    logic              w_start_short;
    logic              w_start_mixed;
    logic [1:0]        w_rom_sfreq;
    logic [3:0]        w_rom_sfb;
    logic [6:0]        w_rom_width;

    always_comb begin
        w_start_short = window_switching_flag && (block_type == 2'd2);
        w_start_mixed = w_start_short && mixed_block_flag;
        w_rom_sfreq   = r_sfreq;
        w_rom_sfb     = r_sfb + 4'd1;
        if (r_state == ST_IDLE) begin
            w_rom_sfreq = sfreq;
            w_rom_sfb   = w_start_mixed ? 4'(MIXED_FIRST_SFB) : 4'd0;
        end
    end

    sfb_width_rom u_sfb_width_rom (
        .sfreq (w_rom_sfreq),
        .sfb   (w_rom_sfb),
        .width (w_rom_width)
    );

    // ------------------------------------------------------------------
    // Next short-walk position (window innermost, then freq, then band)
    // and the address of that position.
    // ------------------------------------------------------------------
    logic              w_last_win;
    logic              w_last_freq;
    logic              w_sfb_end;
    logic [1:0]        w_win_n;
    logic [6:0]        w_freq_n;
    logic [3:0]        w_sfb_n;
    logic [6:0]        w_w_n;
    logic [ADDR_W-1:0] w_w3;
    logic [ADDR_W-1:0] w_base_n;
    logic [ADDR_W-1:0] w_win_off;
    logic [ADDR_W-1:0] w_addr_n;

    always_comb begin
        w_last_win  = (r_win == 2'd2);
        w_last_freq = (r_freq == (r_w - 7'd1));
        w_sfb_end   = w_last_win && w_last_freq;

        w_win_n  = w_last_win ? 2'd0 : (r_win + 2'd1);
        w_freq_n = r_freq;
        if (w_last_win) begin
            w_freq_n = w_last_freq ? 7'd0 : (r_freq + 7'd1);
        end
        w_sfb_n  = w_sfb_end ? (r_sfb + 4'd1) : r_sfb;
        w_w_n    = w_sfb_end ? w_rom_width : r_w;

        // 3w = 2w + w
        w_w3     = ADDR_W'({r_w, 1'b0}) + ADDR_W'(r_w);
        w_base_n = w_sfb_end ? (r_base + w_w3) : r_base;

        // win * w with win in 0..2
        case (w_win_n)
            2'd0:    w_win_off = '0;
            2'd1:    w_win_off = ADDR_W'(w_w_n);
            default: w_win_off = ADDR_W'({w_w_n, 1'b0});
        endcase

        w_addr_n = w_base_n + w_win_off + ADDR_W'(w_freq_n);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grch    <= 2'd0;
            r_sfreq   <= 2'd0;
            r_mixed   <= 1'b0;
            r_ident   <= 1'b0;
            r_sfb     <= 4'd0;
            r_freq    <= 7'd0;
            r_win     <= 2'd0;
            r_w       <= 7'd0;
            r_base    <= '0;
            r_rd_addr <= '0;
            r_out_idx <= '0;
            r_rd_v    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_grch    <= grch_in;
                        r_sfreq   <= sfreq;
                        r_mixed   <= w_start_mixed;
                        // Long blocks stay in identity for the whole granule;
                        // mixed blocks leave it after the long part.
                        r_ident   <= !w_start_short || w_start_mixed;
                        r_sfb     <= w_start_mixed ? 4'(MIXED_FIRST_SFB) : 4'd0;
                        r_freq    <= 7'd0;
                        r_win     <= 2'd0;
                        r_w       <= w_rom_width;
                        r_base    <= w_start_mixed ? c_mixed_base : '0;
                        // Position 0 maps to address 0 in every mode.
                        r_rd_addr <= '0;
                        r_out_idx <= '0;
                        r_rd_v    <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (r_rd_v && rd_ready) begin
                        if (r_out_idx == c_last_idx) begin
                            r_state   <= ST_DONE;
                            r_rd_v    <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_rd_addr <= '0;
                            r_out_idx <= '0;
                        end else begin
                            r_out_idx <= r_out_idx + ADDR_W'(1);
                            if (r_ident) begin
                                // The short walk was pre-positioned at band 3,
                                // base 36, so its first address (36) matches
                                // the identity continuation and no extra
                                // step is needed at the hand-over.
                                r_rd_addr <= r_out_idx + ADDR_W'(1);
                                if (r_mixed && (r_out_idx == c_mixed_end)) begin
                                    r_ident <= 1'b0;
                                end
                            end else begin
                                r_win     <= w_win_n;
                                r_freq    <= w_freq_n;
                                r_sfb     <= w_sfb_n;
                                r_w       <= w_w_n;
                                r_base    <= w_base_n;
                                r_rd_addr <= w_addr_n;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr  = r_rd_addr;
    assign out_idx  = r_out_idx;
    assign grch_out = r_grch;
    assign rd_v     = r_rd_v;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reorder_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_reader
//  Description : Self-checking bench for reorder_reader. Expected addresses
//                come from a table-driven model of the long/short/mixed
//                sample ordering; rd_ready is randomised.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reorder_reader;

    localparam int N = 576;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] grch_in = 2'd0;
    logic       window_switching_flag = 1'b0;
    logic [1:0] block_type = 2'd0;
    logic       mixed_block_flag = 1'b0;
    logic [1:0] sfreq = 2'd0;
    logic       rd_ready = 1'b0;
    logic [9:0] rd_addr;
    logic [9:0] out_idx;
    logic [1:0] grch_out;
    logic       rd_v;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int exp_addr [N];

    int c_width [3][13] = '{
        '{4, 4, 4, 4, 6, 8, 10, 12, 14, 18, 22, 30, 56},
        '{4, 4, 4, 4, 6, 6, 10, 12, 14, 16, 20, 26, 66},
        '{4, 4, 4, 4, 6, 8, 12, 16, 20, 26, 34, 42, 12}
    };

    reorder_reader #(.SAMPLES(576), .ADDR_W(10)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .grch_in               (grch_in),
        .window_switching_flag (window_switching_flag),
        .block_type            (block_type),
        .mixed_block_flag      (mixed_block_flag),
        .sfreq                 (sfreq),
        .rd_ready              (rd_ready),
        .rd_addr               (rd_addr),
        .out_idx               (out_idx),
        .grch_out              (grch_out),
        .rd_v                  (rd_v),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Frequency-order position -> buffer address, straight from the ordering rules.
    function automatic void build_model(input bit is_short, input bit is_mixed, input int rate);
        int idx;
        int base;
        int first;
        int w;
        idx   = 0;
        base  = 0;
        first = 0;
        if (!is_short) begin
            for (int i = 0; i < N; i++) exp_addr[i] = i;
        end else begin
            if (is_mixed) begin
                for (int i = 0; i < 36; i++) exp_addr[i] = i;
                idx   = 36;
                base  = 36;
                first = 3;
            end
            for (int b = first; b < 13; b++) begin
                w = c_width[rate][b];
                for (int f = 0; f < w; f++) begin
                    for (int win = 0; win < 3; win++) begin
                        exp_addr[idx] = base + win * w + f;
                        idx++;
                    end
                end
                base += 3 * w;
            end
        end
    endfunction

    task automatic run_gran(input bit wsf, input bit [1:0] bt, input bit mx, input bit [1:0] sf,
                            input bit [1:0] tag, input int stall, input int mid_beat, input int reset_beat);
        int  k;
        int  cyc;
        bit  prev_stall;
        bit  mid_done;
        logic [9:0] pa;
        logic [9:0] pi;
        bit  is_short;

        is_short = wsf && (bt == 2'd2);
        build_model(is_short, is_short && mx, (sf == 2'd3) ? 0 : int'(sf));

        window_switching_flag = wsf;
        block_type            = bt;
        mixed_block_flag      = mx;
        sfreq                 = sf;
        grch_in               = tag;
        start                 = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_rd_v", rd_v, 1);
        check("start_idx", out_idx, 0);

        k = 0; cyc = 0; prev_stall = 0; mid_done = 0; pa = '0; pi = '0;
        while (k < N && cyc < 20000) begin
            start = 1'b0;
            if (prev_stall) begin
                check("hold_addr", rd_addr, pa);
                check("hold_idx", out_idx, pi);
            end
            check("rd_v", rd_v, 1);
            if (!rd_v) break;
            if (k == reset_beat) begin
                rst_n = 1'b0;
                #1;
                check("rst_addr", rd_addr, 0);
                check("rst_idx", out_idx, 0);
                check("rst_grch", grch_out, 0);
                check("rst_rd_v", rd_v, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                rd_ready = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("post_rst_rd_v", rd_v, 0);
                check("post_rst_done", done, 0);
                check("post_rst_busy", busy, 0);
                return;
            end
            if (k == mid_beat && !mid_done) begin
                // Conflicting request while busy; must leave the granule alone.
                mid_done              = 1;
                start                 = 1'b1;
                window_switching_flag = ~wsf;
                block_type            = ~bt;
                mixed_block_flag      = ~mx;
                sfreq                 = sf + 2'd1;
                grch_in               = ~tag;
            end
            rd_ready = ($urandom_range(0, 99) >= stall);
            if (rd_ready) begin
                check("addr", rd_addr, exp_addr[k]);
                check("idx", out_idx, k);
                check("grch", grch_out, tag);
                k++;
            end
            prev_stall = !rd_ready;
            pa = rd_addr;
            pi = out_idx;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("beats", k, N);
        check("done", done, 1);
        check("end_rd_v", rd_v, 0);
        check("end_busy", busy, 0);
        // A start that lands on the done cycle is not taken.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_on_done_busy", busy, 0);
        check("start_on_done_rd_v", rd_v, 0);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_addr", rd_addr, 0);
        check("reset_idx", out_idx, 0);
        check("reset_grch", grch_out, 0);
        check("reset_rd_v", rd_v, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_gran(1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 0,  -1,  -1);  // long
        run_gran(1'b1, 2'd2, 1'b0, 2'd0, 2'd1, 0,  -1,  -1);  // short 44.1k
        run_gran(1'b1, 2'd2, 1'b1, 2'd1, 2'd3, 0,  -1,  -1);  // short mixed 48k
        run_gran(1'b0, 2'd2, 1'b0, 2'd3, 2'd0, 0,  -1,  -1);  // type 2 without flag -> long
        run_gran(1'b1, 2'd2, 1'b0, 2'd2, 2'd2, 40, 100, -1);  // short 32k, stalls, start while busy
        run_gran(1'b1, 2'd1, 1'b1, 2'd1, 2'd1, 30, -1,  -1);  // start block -> long
        run_gran(1'b1, 2'd2, 1'b0, 2'd0, 2'd3, 20, -1,  300); // reset mid-granule
        run_gran(1'b1, 2'd2, 1'b0, 2'd0, 2'd3, 20, -1,  -1);  // fresh granule after reset
        run_gran(1'b1, 2'd2, 1'b1, 2'd3, 2'd0, 50, 100, -1);  // mixed, rate code 3

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
